fifo_readout_arbiter: RTL and testbench

//  Shares a single downstream transmit path among NUM_FIFOS channel FIFOs (fifo_latch instances).

---
 rtl/fifo_readout_arbiter_pkg.sv | 17 +
 rtl/fifo_readout_arbiter_picker.sv | 33 +++
 rtl/fifo_readout_arbiter.sv | 146 ++++++++++++++
 tb/tb_fifo_readout_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_readout_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// madcap_readout_pkg : shared types for the FIFO readout arbiter
// Rev 1.0
// ============================================================================
package madcap_readout_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } rdo_state_t;

  localparam int RDO_CNT_BITS_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/fifo_readout_arbiter_picker.sv
`default_nettype none
// ============================================================================
// rr_priority_picker : combinational round-robin search upward from ptr+1
// Rev 1.0
// ============================================================================
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  int w_pos;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    any   = 1'b0;
    idx   = '0;
    w_pos = 0;
    for (int k = N; k >= 1; k--) begin
      w_pos = (int'(ptr) + k) % N;
      if (req[w_pos]) begin
        any = 1'b1;
        idx = IW'(w_pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_readout_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_readout_arbiter : reads channel FIFOs one word at a time, urgent
// (half-full) FIFOs first, and presents each word on a valid/ready port.
// Rev 1.0
// ============================================================================
module fifo_readout_arbiter
  import madcap_readout_pkg::*;
#(
  parameter int NUM_FIFOS  = 4,
  parameter int FIFO_WIDTH = 64,
  parameter int ID_BITS    = $clog2(NUM_FIFOS),
  parameter int CNT_BITS   = RDO_CNT_BITS_DEF
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [NUM_FIFOS-1:0]            fifo_empty,
  input  logic [NUM_FIFOS-1:0]            fifo_half,
  input  logic [NUM_FIFOS*FIFO_WIDTH-1:0] fifo_data,
  output logic [NUM_FIFOS-1:0]            read_n,
  output logic [FIFO_WIDTH-1:0]           tx_data,
  output logic [ID_BITS-1:0]              tx_id,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  output logic                            busy,
  output logic [CNT_BITS-1:0]             words_sent
);

  localparam logic [ID_BITS-1:0] C_PTR_RESET = ID_BITS'(NUM_FIFOS - 1);

  logic [NUM_FIFOS-1:0]  w_req;
  logic [NUM_FIFOS-1:0]  w_urg;
  logic                  w_req_any;
  logic                  w_urg_any;
  logic [ID_BITS-1:0]    w_req_idx;
  logic [ID_BITS-1:0]    w_urg_idx;
  logic [ID_BITS-1:0]    w_grant;
  logic [FIFO_WIDTH-1:0] w_fifo_word [NUM_FIFOS];

  rdo_state_t            r_state;
  rdo_state_t            w_next_state;
  logic                  w_load_gnt;
  logic [ID_BITS-1:0]    r_gnt;
  logic [ID_BITS-1:0]    r_rr_ptr;
  logic [FIFO_WIDTH-1:0] r_tx_data;
  logic [ID_BITS-1:0]    r_tx_id;
  logic                  r_tx_valid;
  logic [CNT_BITS-1:0]   r_words_sent;

  assign w_req = ~fifo_empty;
  assign w_urg = w_req & fifo_half;

  generate
    for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_unpack
      assign w_fifo_word[i] = fifo_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  endgenerate

  rr_priority_picker #(.N(NUM_FIFOS), .IW(ID_BITS)) u_pick_urg (
    .req (w_urg),
    .ptr (r_rr_ptr),
    .any (w_urg_any),
    .idx (w_urg_idx)
  );

  rr_priority_picker #(.N(NUM_FIFOS), .IW(ID_BITS)) u_pick_req (
    .req (w_req),
    .ptr (r_rr_ptr),
    .any (w_req_any),
    .idx (w_req_idx)
  );

  assign w_grant = w_urg_any ? w_urg_idx : w_req_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load_gnt   = 1'b0;
    read_n       = '1;
    case (r_state)
      IDLE: begin
        if (enable && w_req_any) begin
          w_next_state = READ;
          w_load_gnt   = 1'b1;
        end
      end
      READ: begin
        read_n[r_gnt] = 1'b0;
        w_next_state  = SEND;
      end
      SEND: begin
        // Flags seen here already reflect the read pulse of the previous READ.
        if (tx_ready) begin
          if (enable && w_req_any) begin
            w_next_state = READ;
            w_load_gnt   = 1'b1;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt        <= '0;
      r_rr_ptr     <= C_PTR_RESET;
      r_tx_data    <= '0;
      r_tx_id      <= '0;
      r_tx_valid   <= 1'b0;
      r_words_sent <= '0;
    end else begin
      if (w_load_gnt) begin
        r_gnt    <= w_grant;
        r_rr_ptr <= w_grant;
      end
      if (r_state == READ) begin
        r_tx_data  <= w_fifo_word[r_gnt];
        r_tx_id    <= r_gnt;
        r_tx_valid <= 1'b1;
      end
      if (r_state == SEND && tx_ready) begin
        r_tx_valid   <= 1'b0;
        r_words_sent <= r_words_sent + CNT_BITS'(1);
      end
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_id      = r_tx_id;
  assign tx_valid   = r_tx_valid;
  assign busy       = (r_state != IDLE);
  assign words_sent = r_words_sent;

endmodule
`default_nettype wire

// File: tb/tb_fifo_readout_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fifo_readout_arbiter : FIFO models plus a queue-based reference model
// Rev 1.0
// ============================================================================
module tb_fifo_readout_arbiter;

  localparam int N    = 4;
  localparam int W    = 64;
  localparam int IB   = 2;
  localparam int CB   = 16;
  localparam int HALF = 3;

  typedef struct packed {
    logic [IB-1:0] id;
    logic [W-1:0]  data;
  } item_t;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           enable = 1'b1;
  logic           tx_ready = 1'b0;
  logic [N-1:0]   fifo_empty = '1;
  logic [N-1:0]   fifo_half = '0;
  logic [N*W-1:0] fifo_data = '0;
  logic [N-1:0]   read_n;
  logic [W-1:0]   tx_data;
  logic [IB-1:0]  tx_id;
  logic           tx_valid;
  logic           busy;
  logic [CB-1:0]  words_sent;

  logic [W-1:0] q [N][$];
  item_t        pend[$];
  int           glog[$];
  int           gcyc[$];
  int           acc_cyc[$];
  bit           seen[logic [W-1:0]];
  int           cyc = 0;
  int           acc = 0;
  int           rr  = N - 1;
  bit           exp_valid = 1'b0;
  int           n_cmp = 0;
  int           n_err = 0;

  fifo_readout_arbiter #(
    .NUM_FIFOS(N), .FIFO_WIDTH(W), .ID_BITS(IB), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_half(fifo_half), .fifo_data(fifo_data),
    .read_n(read_n), .tx_data(tx_data), .tx_id(tx_id), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Urgent FIFOs win; otherwise any non-empty one; first hit scanning up from rr+1.
  function automatic int model_pick(input logic [N-1:0] ne, input logic [N-1:0] hf, input int ptr);
    logic [N-1:0] cand;
    cand = ((ne & hf) != 0) ? (ne & hf) : ne;
    for (int k = 1; k <= N; k++)
      if (cand[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic load(input int i, input int n);
    for (int k = 0; k < n; k++) q[i].push_back({$urandom, $urandom});
  endtask

  function automatic int total_words();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += q[i].size();
    return s;
  endfunction

  // FIFO behaviour and scoreboard: everything here is sampled mid-cycle.
  always @(negedge clk) begin
    int    lows;
    int    gi;
    int    pick;
    item_t it;
    cyc++;
    if (!reset_n) begin
      pend.delete();
      rr        = N - 1;
      acc       = 0;
      exp_valid = 1'b0;
      check_eq("rst_read_n", read_n, {N{1'b1}});
      check_eq("rst_tx_valid", tx_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_words_sent", words_sent, 0);
    end else begin
      lows = 0;
      gi   = -1;
      for (int i = 0; i < N; i++) if (!read_n[i]) begin lows++; gi = i; end
      check_eq("single_read", lows, (lows > 1) ? 1 : lows);
      if (pend.size() == 0) check_eq("valid_without_word", tx_valid, 0);
      if (exp_valid) begin
        check_eq("read_to_valid", tx_valid, 1);
        exp_valid = 1'b0;
      end
      if (gi >= 0) begin
        pick = model_pick(~fifo_empty, fifo_half, rr);
        check_eq("grant", gi, pick);
        check_eq("read_nonempty", fifo_empty[gi], 0);
        check_eq("read_busy", busy, 1);
        rr = gi;
        glog.push_back(gi);
        gcyc.push_back(cyc);
        if (q[gi].size() > 0) begin
          it.id   = IB'(gi);
          it.data = q[gi].pop_front();
          fifo_data[gi*W +: W] = it.data;
          pend.push_back(it);
        end
        exp_valid = 1'b1;
      end
      if (tx_valid && tx_ready) begin
        if (pend.size() == 0) begin
          check_eq("accept_no_word", tx_valid, 0);
        end else begin
          it = pend.pop_front();
          check_eq("tx_id", tx_id, it.id);
          check_eq("tx_data", tx_data, it.data);
          check_eq("duplicate", seen.exists(tx_data), 0);
          seen[tx_data] = 1'b1;
          check_eq("words_sent", words_sent, acc % (1 << CB));
          acc++;
          acc_cyc.push_back(cyc);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (q[i].size() == 0);
      fifo_half[i]  = (q[i].size() >= HALF);
    end
  end

  task automatic wait_idle(input int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk); #1;
      if (total_words() == 0 && !busy && !tx_valid) return;
    end
    check_eq("idle_timeout", busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          l0;
    int          base;
    int          ok;
    logic [W-1:0] hold_d;
    logic [IB-1:0] hold_id;
    int          exp3[5] = '{1, 1, 1, 2, 0};

    // Reset, all empty
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      check_eq("idle_read_n", read_n, {N{1'b1}});
      check_eq("idle_tx_valid", tx_valid, 0);
      check_eq("idle_busy", busy, 0);
    end

    // One word each in FIFOs 0,1,2
    glog.delete(); gcyc.delete(); acc_cyc.delete();
    tx_ready = 1'b1;
    @(posedge clk); #2;
    l0 = cyc;
    load(0, 1); load(1, 1); load(2, 1);
    wait_idle(100);
    check_eq("p2_count", glog.size(), 3);
    if (glog.size() == 3) begin
      for (int i = 0; i < 3; i++) check_eq("p2_order", glog[i], i);
      check_eq("p2_read_latency", gcyc[0] - l0, 2);
    end
    check_eq("p2_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      check_eq("p2_valid_latency", acc_cyc[0] - l0, 3);
      check_eq("p2_spacing_a", acc_cyc[1] - acc_cyc[0], 2);
      check_eq("p2_spacing_b", acc_cyc[2] - acc_cyc[1], 2);
    end
    check_eq("p2_words_sent", words_sent, 3);

    // Half-full FIFO1 goes first
    glog.delete();
    @(posedge clk); #2;
    load(1, 5); load(0, 1); load(2, 1);
    wait_idle(200);
    check_eq("p3_count", glog.size(), 7);
    if (glog.size() >= 5)
      for (int i = 0; i < 5; i++) check_eq("p3_order", glog[i], exp3[i]);

    // Backpressure
    glog.delete();
    tx_ready = 1'b0;
    @(posedge clk); #2;
    load(3, 1);
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk); #1;
      if (tx_valid) ok = 1;
    end
    check_eq("p4_valid_seen", tx_valid, 1);
    hold_d  = tx_data;
    hold_id = tx_id;
    base    = int'(words_sent);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      check_eq("p4_hold_valid", tx_valid, 1);
      check_eq("p4_hold_data", tx_data, hold_d);
      check_eq("p4_hold_id", tx_id, hold_id);
      check_eq("p4_no_read", read_n, {N{1'b1}});
    end
    @(posedge clk); #2 tx_ready = 1'b1;
    @(posedge clk); #2 tx_ready = 1'b0;
    @(negedge clk); #1;
    check_eq("p4_words_sent", words_sent, base + 1);
    check_eq("p4_valid_drop", tx_valid, 0);
    check_eq("p4_reads", glog.size(), 1);

    // enable dropped during READ
    glog.delete();
    tx_ready = 1'b1;
    @(posedge clk); #2;
    load(0, 2); load(1, 2);
    for (int c = 0; c < 20 && read_n == {N{1'b1}}; c++) begin
      @(negedge clk); #1;
    end
    check_eq("p5_read_seen", (read_n != {N{1'b1}}), 1);
    enable = 1'b0;
    base   = int'(words_sent);
    repeat (10) begin
      @(negedge clk); #1;
    end
    check_eq("p5_words_sent", words_sent, base + 1);
    check_eq("p5_reads", glog.size(), 1);
    check_eq("p5_busy", busy, 0);
    check_eq("p5_left", total_words(), 3);
    enable = 1'b1;
    wait_idle(100);

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #2;
      tx_ready = ($urandom_range(0, 3) != 0);
      enable   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 2) == 0) begin
        int f;
        f = $urandom_range(0, N - 1);
        if (q[f].size() < 7) load(f, $urandom_range(1, 3));
      end
    end
    enable   = 1'b1;
    tx_ready = 1'b1;
    wait_idle(500);

    // Reset while a word is held in SEND
    tx_ready = 1'b0;
    @(posedge clk); #2;
    load(2, 3); load(3, 2);
    for (int c = 0; c < 20 && !tx_valid; c++) begin
      @(negedge clk); #1;
    end
    check_eq("p6_in_send", tx_valid, 1);
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    check_eq("p6_read_n", read_n, {N{1'b1}});
    check_eq("p6_tx_valid", tx_valid, 0);
    check_eq("p6_tx_data", tx_data, 0);
    check_eq("p6_tx_id", tx_id, 0);
    check_eq("p6_busy", busy, 0);
    check_eq("p6_words_sent", words_sent, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tx_ready = 1'b1;
    wait_idle(200);
    check_eq("p6_drained", total_words(), 0);
    check_eq("p6_final_count", words_sent, acc % (1 << CB));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
